// File: rtl/tff_count_controller_pkg.sv
// Shared definitions for the toggle flip-flop counter controller:
// FSM state encoding and default parameter values.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_PRESCALE = 4;

endpackage

// File: rtl/tff_count_controller_cell.sv
// tff_cell: a single toggle flip-flop counter bit with a synchronous
// active-low reset and a synchronous clear driven by the controller.
// The clear has priority over the toggle enable.
module tff_cell (
    input  logic clock,
    input  logic clear_n,
    input  logic enable,
    input  logic sclr,
    output logic q,
    output logic q_not
);

    logic q_d;
    logic q_q;

    // Next value: clear first, otherwise toggle when enabled
    always_comb begin
        q_d = q_q;
        if (sclr) begin
            q_d = 1'b0;
        end else if (enable) begin
            q_d = ~q_q;
        end
    end

    // Bit storage with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_not = ~q_q;

endmodule

// File: rtl/tff_count_controller.sv
// tff_count_controller: sequences a bank of WIDTH toggle cells from 0 up to
// a sampled terminal value, with pause, abort and optional modulo wrap.
// Optional feature macro: TFF_CTRL_PRESCALE_EN (adds a PRESCALE-cycle tick
// divider; when undefined the counter ticks every RUN cycle).
module tff_count_controller
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             wrap,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle_en,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             sclr;
    logic             start_ok;
    logic             run_adv;
    logic             presc_hit;
    logic             tick;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] inc_en;
    logic             at_limit;
    logic             hits_limit;

    // A start is only honoured from IDLE/DONE and loses to reset and stop.
    assign start_ok = clear_n & ~stop & start &
                      ((state_q == ST_IDLE) | (state_q == ST_DONE));
    // The count and prescaler advance only in RUN with nothing higher-priority pending.
    assign run_adv  = clear_n & ~stop & ~pause & (state_q == ST_RUN);
    assign tick     = run_adv & presc_hit;

`ifdef TFF_CTRL_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;

    assign presc_hit = (presc_q == PW'(PRESCALE - 1));

    // Prescaler: cleared by an accepted start, advances and wraps in RUN, holds otherwise
    always_comb begin
        presc_d = presc_q;
        if (start_ok) begin
            presc_d = '0;
        end else if (run_adv) begin
            presc_d = presc_hit ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Without the divider every RUN cycle is a tick; an illegal PRESCALE of 0 stalls.
    assign presc_hit = (PRESCALE >= 1);
`endif

    assign count_inc  = count + WIDTH'(1);
    assign at_limit   = (count == limit_q);
    assign hits_limit = (count_inc == limit_q);

    // Increment enables: bit i toggles when all lower bits are ones
    always_comb begin
        logic carry;
        carry  = 1'b1;
        inc_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inc_en[i] = carry;
            carry     = carry & ~count_n[i];
        end
    end

    // At the limit (wrap only) toggling every set bit returns the count to 0.
    assign toggle_en = !tick    ? '0 :
                       at_limit ? count : inc_en;

    // Next-state, sampled-operand and completion-pulse logic
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        sclr    = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            sclr    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        sclr    = 1'b1;
                        limit_d = limit;
                        wrap_d  = wrap;
                        if ((limit == '0) && !wrap) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (at_limit) begin
                            done_d = 1'b1;
                        end else if (hits_limit && !wrap_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock   (clock),
            .clear_n (clear_n),
            .enable  (toggle_en[i]),
            .sclr    (sclr),
            .q       (count[i]),
            .q_not   (count_n[i])
        );
    end

    assign busy = (state_q == ST_RUN) | (state_q == ST_PAUSE);
    assign done = done_q;

endmodule

// File: tb/tb_tff_count_controller.sv
// Scoreboard bench for tff_count_controller: the driver computes the expected
// per-cycle outputs from an arithmetic reference model and queues them; the
// monitor pops one entry per cycle on the falling edge and compares.
module tb_tff_count_controller;

    localparam int W = 4;
    localparam int P = 4;
`ifdef TFF_CTRL_PRESCALE_EN
    localparam int EFF_P = P;
`else
    localparam int EFF_P = 1;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clock = 1'b0;
    logic         clear_n, start, pause, stop, wrap;
    logic [W-1:0] limit;
    logic [W-1:0] count, toggle_en;
    logic         busy, done;

    tff_count_controller #(.WIDTH(W), .PRESCALE(P)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .wrap      (wrap),
        .limit     (limit),
        .count     (count),
        .toggle_en (toggle_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [W-1:0] te;
        logic         dn;
        logic         bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model: run mode, count as an integer, sampled operands, tick phase
    int mmode = M_IDLE;
    int mcnt  = 0;
    int mlim  = 0;
    int mph   = 0;
    bit mwrp  = 1'b0;
    bit mdone = 1'b0;
    bit mvalid = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
    endtask

    // one clock cycle of stimulus plus the model's expectation for that cycle
    task automatic cyc(input bit rn, input bit st, input bit sp, input bit pa,
                       input bit wr, input logic [W-1:0] lm);
        int   nxt;
        bit   tk;
        exp_t e;
        @(posedge clock);
        #1;
        clear_n = rn; start = st; stop = sp; pause = pa; wrap = wr; limit = lm;
        tk  = rn && !sp && mvalid && (mmode == M_RUN) && !pa && (mph == EFF_P - 1);
        nxt = mwrp ? (mcnt + 1) % (mlim + 1) : mcnt + 1;
        if (mvalid) begin
            e.cnt = W'(mcnt);
            e.te  = tk ? W'(mcnt ^ nxt) : '0;
            e.dn  = mdone;
            e.bz  = (mmode == M_RUN) || (mmode == M_PAUSE);
            exp_q.push_back(e);
        end
        if (!rn) begin
            mmode = M_IDLE; mcnt = 0; mdone = 0; mph = 0; mlim = 0; mwrp = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            mdone = 1'b0;
            if (sp) begin
                mmode = M_IDLE; mcnt = 0;
            end else begin
                case (mmode)
                    M_IDLE, M_DONE: if (st) begin
                        mlim = int'(lm); mwrp = wr; mph = 0; mcnt = 0;
                        if (mlim == 0 && !wr) begin
                            mmode = M_DONE; mdone = 1'b1;
                        end else begin
                            mmode = M_RUN;
                        end
                    end
                    M_RUN: if (pa) begin
                        mmode = M_PAUSE;
                    end else if (mph == EFF_P - 1) begin
                        mph   = 0;
                        mcnt  = nxt;
                        mdone = mwrp ? (nxt == 0) : (nxt == mlim);
                        if (!mwrp && nxt == mlim) mmode = M_DONE;
                    end else begin
                        mph++;
                    end
                    default: if (!pa) mmode = M_RUN;
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, '0);
    endtask

    task automatic run_until(input int target, input int maxc);
        int k;
        k = 0;
        while (!(mmode == M_RUN && mcnt == target) && k < maxc) begin
            cyc(1, 0, 0, 0, 0, '0);
            k++;
        end
        n_checks++;
        if (k < maxc) n_pass++;
        else $display("FAIL run_until: count %0d not reached within %0d cycles", target, maxc);
    endtask

    // monitor: one expectation per cycle, compared on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", count, e.cnt);
                chk("toggle_en", toggle_en, e.te);
                chk("done", W'(done), W'(e.dn));
                chk("busy", W'(busy), W'(e.bz));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; wrap = 1'b0; limit = '0;
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        idle(2);
        // limit 5, no wrap: count to 5, done once, hold in DONE
        cyc(1, 1, 0, 0, 0, 4'd5);
        idle(10 * EFF_P);
        // start during DONE with a new limit, wrap 3
        cyc(1, 1, 0, 0, 1, 4'd3);
        idle(14 * EFF_P);
        cyc(1, 0, 1, 0, 0, '0);
        idle(2);
        // pause at 4 for 4 cycles, then stop at 6
        cyc(1, 1, 0, 0, 0, 4'd9);
        run_until(4, 20 * EFF_P);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, '0);
        run_until(6, 20 * EFF_P);
        cyc(1, 0, 1, 0, 0, '0);
        idle(3);
        // limit 0 with and without wrap
        cyc(1, 1, 0, 0, 0, 4'd0);
        idle(3);
        cyc(1, 1, 0, 0, 1, 4'd0);
        idle(5 * EFF_P);
        cyc(1, 0, 1, 0, 0, '0);
        idle(2);
        // reset in the middle of a run
        cyc(1, 1, 0, 0, 0, 4'd12);
        run_until(7, 20 * EFF_P);
        cyc(0, 0, 0, 0, 0, '0);
        idle(2);
        // full-range wrap with ignored starts during RUN
        cyc(1, 1, 0, 0, 1, 4'd15);
        idle(20 * EFF_P);
        cyc(1, 1, 0, 0, 0, 4'd2);
        idle(3);
        cyc(1, 1, 0, 0, 1, 4'd1);
        idle(20 * EFF_P);
        cyc(1, 0, 1, 0, 0, '0);
        // limit 2 run (prescaled timing when enabled)
        cyc(1, 1, 0, 0, 0, 4'd2);
        idle(4 * EFF_P + 4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 5) == 0),
                bit'($urandom_range(0, 1)),
                W'($urandom_range(0, 15)));
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tff_count_controller.md
# tff_count_controller

Sequencer for a bank of toggle flip-flop counter cells. On command it runs the counter from 0 to a programmable terminal value and generates per-bit toggle enables. It handles pause, abort and optional wrap, and signals completion with a one-cycle `done` pulse. It sits between the lab's control inputs (push-buttons and switches, already synchronised) and the toggle-cell datapath. It is the only driver of the cells' enable and clear pins.

## Interface
- `WIDTH`, default 4: counter bits, one toggle cell per bit.
- `PRESCALE`, default 4: clock cycles per count tick. Must be ≥1. Only used with `PRESCALE_EN`.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `clear_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: single-cycle command. Begins a run from 0 and samples `limit`.
- `pause`, in, 1: level signal. Holds the count while high.
- `stop`, in, 1: single-cycle abort. Returns to IDLE with the count cleared.
- `wrap`, in, 1: level signal, sampled with `start`. 1 means continuous modulo-(`limit`+1) counting.
- `limit`, in, `WIDTH`: terminal count, sampled on an accepted `start`.
- `count`, out, `WIDTH`: current cell outputs (Q of each toggle cell).
- `toggle_en`, out, `WIDTH`: per-bit toggle enables, combinational from state, tick and `count`.
- `busy`, out, 1: high in RUN and PAUSE.
- `done`, out, 1: registered one-cycle completion pulse.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Reset (`clear_n`=0 at an edge) forces the following, regardless of the current state, including mid-run:
  - state=IDLE;
  - `count`=0, `done`=0, `busy`=0, `toggle_en`=0;
  - prescaler=0, sampled limit=0, sampled wrap=0.
- Input priority in each cycle: `clear_n` > `stop` > `start` > `pause` > tick.
- IDLE:
  - `start` samples `limit`/`wrap`, clears the prescaler and goes to RUN.
  - If the sampled limit is 0 and `wrap`=0, it goes straight to DONE and pulses `done`.
- RUN:
  - On a tick with `count` ≠ limit, the count increments.
  - `toggle_en[0]`=tick.
  - `toggle_en[i]`=tick & (`count[i-1:0]` all ones).
- RUN, when `count`+1 == limit on a tick:
  - Without wrap: next state is DONE and `done` pulses in the same cycle `count` first equals limit.
  - With wrap: stay in RUN.
- RUN with wrap, on a tick when `count` == limit:
  - `toggle_en` = `count`, so every set bit toggles and the count returns to 0.
  - `done` pulses in the cycle `count` reads 0.
- Maximum limit (all ones) with wrap: natural rollover through the toggle chain gives the same result.
- RUN to PAUSE while `pause`=1. PAUSE to RUN when `pause`=0. In PAUSE, `toggle_en`=0 and the prescaler holds.
- DONE:
  - `count` holds at limit and `busy`=0.
  - `start` begins a new run: the count is cleared via the cells' clear and the next run starts from 0.
  - `stop` goes to IDLE with the count cleared.
- `stop` in any state: next state IDLE, `count`=0 on the next edge, no `done` pulse.
- `start` while in RUN or PAUSE is ignored.
- `limit` changes after sampling have no effect until the next `start`.

## Timing
- `start` is seen at edge t. The state is RUN from t+1.
- First tick: at t+1 without `PRESCALE_EN`, or at t+`PRESCALE` with it.
- Count latency: a tick asserted in cycle c updates `count` at the edge ending cycle c.
- A limit of L with no pause gives `done` high for the cycle `count`=L, which begins L×`PRESCALE` cycles after the first RUN cycle. `PRESCALE` is read as 1 when the feature is compiled out.
- `done` is never high for two consecutive cycles, except with wrap at `limit`=0 and `PRESCALE`=1, where it is high every cycle.
- `stop` or `clear_n` at the same edge as a terminal tick wins, and no `done` is produced.

## Configuration
- `TFF_CTRL_PRESCALE_EN` defined:
  - Instantiates a `$clog2(PRESCALE)`-bit prescaler.
  - tick = RUN & (prescaler == `PRESCALE`-1); the prescaler then wraps to 0.
- `TFF_CTRL_PRESCALE_EN` undefined: tick = RUN every cycle and `PRESCALE` is ignored.

## Structure
- Shared package `tff_ctrl_pkg`:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - default `WIDTH`/`PRESCALE` constants.
- Sub-module `tff_cell`: one toggle bit with ports `enable`, `clock`, `clear_n` (sync active-low), `sclr` (sync clear from the controller), Q and Qnot. It is instantiated `WIDTH` times in a generate loop.
- The FSM, prescaler, limit compare and enable chain live in the top module.

## Test plan
- Reset, then `start` with `limit`=5, `wrap`=0, `PRESCALE`=1:
  - `count` steps 0→5;
  - `done`=1 only in the cycle `count`=5;
  - state DONE with `busy`=0 and `count` holding 5.
- `limit`=3, `wrap`=1: `count` sequence 1,2,3,0,1,…, with `done` high in each cycle `count` returns to 0.
- Pause and stop:
  - Run with `limit`=9 and assert `pause` for 4 cycles at `count`=4: `count` holds 4 and `toggle_en`=0.
  - Release `pause`, then `stop` at `count`=6: IDLE and `count`=0 next cycle, no `done`.
- Edge limits and mid-run reset:
  - `limit`=0, `wrap`=0: DONE and `done` one cycle after `start`.
  - `clear_n`=0 during RUN at `count`=7: all outputs 0 after that edge.
- With `TFF_CTRL_PRESCALE_EN`, `PRESCALE`=4, `limit`=2: `done` occurs 8 cycles after the first RUN cycle. `start` during RUN is ignored.
